// File: rtl/cnn_pe_pkg.sv
// Shared definitions for the CNN processing-element datapath.
//
// Contents:
//   K_MIN / K_MAX  - legal kernel sizes for window_line_buffer
//   clog2          - ceiling log2 of a positive integer (clog2(1) = 0)
//   cnt_width      - bits needed to hold 0..v-1, never less than 1
//   geometry_ok    - legality test for a LINES/K pair, used at elaboration
//   win_slot       - flat slot index of window element (row, col).
//                    Rows are row-major, newest first, so row 0 / col 0
//                    (the newest pixel) lands in the most significant slot.
package cnn_pe_pkg;

    localparam int K_MIN = 3;
    localparam int K_MAX = 7;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic bit geometry_ok(input int lines, input int k);
        return (k >= K_MIN) && (k <= K_MAX) && (lines > k);
    endfunction

    function automatic int win_slot(input int r, input int c, input int k);
        return (k - 1 - r) * k + (k - 1 - c);
    endfunction

endpackage

// File: rtl/window_line_buffer_line_delay.sv
// line_delay: fixed-depth delay of DEPTH accepted words.
//
// Ports:
//   clk   in  1  rising-edge clock
//   en    in  1  advance strobe; the delay holds when low
//   din   in  W  word entering the delay
//   dout  out W  word that entered DEPTH advances ago
//
// USE_MEM = 1 builds a circular array with one pointer: each advance reads
// the oldest word and overwrites it with din at the same address.
// USE_MEM = 0 builds a plain shift chain. Both present the same dout.
// There is no reset: contents are data only and the pointer phase does not
// matter, because the write-to-read distance is always DEPTH advances.
module line_delay
    import cnn_pe_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEPTH   = 13,
    parameter int USE_MEM = 1
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (USE_MEM != 0) begin : g_ram
            localparam int PW = cnt_width(DEPTH);
            localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

            logic [W-1:0]  mem [DEPTH];
            logic [PW-1:0] ptr;

            always_ff @(posedge clk) begin
                if (en) begin
                    mem[ptr] <= din;
                    // >= rather than == so an out-of-range power-up value
                    // falls back into 0..DEPTH-1 on the first advance.
                    ptr <= (ptr >= PTR_LAST) ? '0 : ptr + 1'b1;
                end
            end

            assign dout = mem[ptr];
        end else begin : g_shift
            logic [W-1:0] chain [DEPTH];

            always_ff @(posedge clk) begin
                if (en) begin
                    chain[0] <= din;
                    for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
                end
            end

            assign dout = chain[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: KxK sliding window and KxK weight staging for a PE.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   sof        in   1      start of frame, only meaningful with en_in
//   d_in       in   N      raster pixel
//   en_in      in   1      pixel accept strobe
//   w_in       in   M      weight word
//   w_conf     in   1      weight shift strobe
//   w_out      out  M      weight cascade to the next PE
//   w_ready    out  1      K*K weights loaded since the last restart
//   d_grp      out  K*K*N  window, row 0 (newest line) and newest column in MSBs
//   w_grp      out  K*K*M  weights, first stage in MSBs
//   win_valid  out  1      d_grp holds a complete window this cycle
//
// Handshake: en_in and w_conf are push-only valid strobes with no ready;
// the block accepts a pixel on every rising edge where en_in=1 and a
// weight on every edge where w_conf=1, independently of each other.
// With both low every register holds.
//
// Row r tap 0 is fed from line delay r-1 (depth LINES-K), which is fed from
// row r-1 tap K-1. K taps plus LINES-K delay stages put exactly LINES
// accepted pixels between consecutive rows, so columns stay aligned.
module window_line_buffer
    import cnn_pe_pkg::*;
#(
    parameter int LINES   = 16,
    parameter int K       = 3,
    parameter int N       = 8,
    parameter int M       = 4,
    parameter int USE_MEM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic [N-1:0]     d_in,
    input  logic             en_in,
    input  logic [M-1:0]     w_in,
    input  logic             w_conf,
    output logic [M-1:0]     w_out,
    output logic             w_ready,
    output logic [K*K*N-1:0] d_grp,
    output logic [K*K*M-1:0] w_grp,
    output logic             win_valid
);

    localparam int D     = LINES - K;
    localparam int KK    = K * K;
    localparam int COL_W = cnt_width(LINES);
    localparam int ROW_W = cnt_width(K);
    localparam int WC_W  = cnt_width(KK + 1);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINES - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(K - 1);
    localparam logic [WC_W-1:0]  W_FULL    = WC_W'(KK);

    generate
        if (!geometry_ok(LINES, K)) begin : g_bad_geometry
            $error("window_line_buffer: illegal geometry LINES=%0d K=%0d", LINES, K);
        end
    endgenerate

    // Line delays must not advance while reset is held, so an en_in that
    // coincides with reset cannot shift stale data along.
    logic ld_en;
    assign ld_en = en_in & rst_n;

    // ---------------------------------------------------------------- window
    logic [N-1:0] tap    [K][K];
    logic [N-1:0] ld_out [K-1];

    generate
        for (genvar r = 1; r < K; r++) begin : g_ld
            line_delay #(
                .W       (N),
                .DEPTH   (D),
                .USE_MEM (USE_MEM)
            ) u_line_delay (
                .clk  (clk),
                .en   (ld_en),
                .din  (tap[r-1][K-1]),
                .dout (ld_out[r-1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++)
                for (int j = 0; j < K; j++)
                    tap[r][j] <= '0;
        end else if (en_in) begin
            tap[0][0] <= d_in;
            for (int r = 1; r < K; r++) tap[r][0] <= ld_out[r-1];
            for (int r = 0; r < K; r++)
                for (int j = 1; j < K; j++)
                    tap[r][j] <= tap[r][j-1];
        end
    end

    generate
        for (genvar r = 0; r < K; r++) begin : g_pack_row
            for (genvar j = 0; j < K; j++) begin : g_pack_col
                assign d_grp[win_slot(r, j, K)*N +: N] = tap[r][j];
            end
        end
    endgenerate

    // ------------------------------------------------------------- position
    // cur_* is the position of the pixel being accepted this edge; a
    // qualified sof overrides the running counters with (0,0).
    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;

    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (en_in) begin
                // Columns below K-1 would mix the previous line's tail.
                win_valid <= (cur_row == ROW_LAST) && (cur_col >= COL_FIRST);
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? cur_row : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

    // -------------------------------------------------------------- weights
    logic [M-1:0]    w_reg [KK];
    logic [WC_W-1:0] w_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < KK; i++) w_reg[i] <= '0;
            w_out <= '0;
            w_cnt <= '0;
        end else if (w_conf) begin
            w_reg[0] <= w_in;
            for (int i = 1; i < KK; i++) w_reg[i] <= w_reg[i-1];
            w_out <= w_reg[KK-1];
            // A load after a full set starts a new set at count 1.
            w_cnt <= (w_cnt == W_FULL) ? WC_W'(1) : w_cnt + 1'b1;
        end
    end

    assign w_ready = (w_cnt == W_FULL);

    generate
        for (genvar i = 0; i < KK; i++) begin : g_pack_w
            assign w_grp[(KK-1-i)*M +: M] = w_reg[i];
        end
    endgenerate

endmodule

// File: tb/tb_window_line_buffer.sv
module tb_window_line_buffer;

  localparam int LINES = 8;
  localparam int K     = 3;
  localparam int N     = 8;
  localparam int M     = 4;
  localparam int KK    = K * K;
  localparam int L5    = 16;
  localparam int K5    = 5;

  // ---------------------------------------------------- clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n  = 1'b0;
  logic             sof    = 1'b0;
  logic             en_in  = 1'b0;
  logic             w_conf = 1'b0;
  logic [N-1:0]     d_in   = '0;
  logic [M-1:0]     w_in   = '0;
  logic [M-1:0]     w_out;
  logic             w_ready;
  logic [K*K*N-1:0] d_grp;
  logic [K*K*M-1:0] w_grp;
  logic             win_valid;

  window_line_buffer #(.LINES(LINES), .K(K), .N(N), .M(M), .USE_MEM(1)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .d_in(d_in), .en_in(en_in),
    .w_in(w_in), .w_conf(w_conf), .w_out(w_out), .w_ready(w_ready),
    .d_grp(d_grp), .w_grp(w_grp), .win_valid(win_valid)
  );

  // K=5 pair: register-chain and RAM line delays on the same stream.
  logic               sof5 = 1'b0;
  logic               en5  = 1'b0;
  logic [7:0]         d5   = '0;
  logic [3:0]         w5_in = '0;
  logic               w5_conf = 1'b0;
  logic [3:0]         w5_out_a, w5_out_b;
  logic               w5_rdy_a, w5_rdy_b;
  logic [K5*K5*8-1:0] d_grp5a, d_grp5b;
  logic [K5*K5*4-1:0] w_grp5a, w_grp5b;
  logic               v5a, v5b;

  window_line_buffer #(.LINES(L5), .K(K5), .N(8), .M(4), .USE_MEM(0)) dut5_reg (
    .clk(clk), .rst_n(rst_n), .sof(sof5), .d_in(d5), .en_in(en5),
    .w_in(w5_in), .w_conf(w5_conf), .w_out(w5_out_a), .w_ready(w5_rdy_a),
    .d_grp(d_grp5a), .w_grp(w_grp5a), .win_valid(v5a)
  );

  window_line_buffer #(.LINES(L5), .K(K5), .N(8), .M(4), .USE_MEM(1)) dut5_ram (
    .clk(clk), .rst_n(rst_n), .sof(sof5), .d_in(d5), .en_in(en5),
    .w_in(w5_in), .w_conf(w5_conf), .w_out(w5_out_b), .w_ready(w5_rdy_b),
    .d_grp(d_grp5b), .w_grp(w_grp5b), .win_valid(v5b)
  );

  // ------------------------------------------------------------ scoreboard
  int vectors    = 0;
  int miscompares = 0;
  bit check_on   = 1'b0;
  bit check5_on  = 1'b0;
  int pulse_cnt  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: full pixel history since reset, frame position from
  // a plain count since the last restart, weight history since reset.
  int                 px_q[$];
  int                 w_q[$];
  int                 pos = 0;
  int                 p_row, p_col;
  bit                 m_valid = 1'b0;
  logic [K*K*N-1:0]   exp_q[$];

  function automatic logic [K*K*N-1:0] model_window();
    logic [K*K*N-1:0] w;
    int last;
    w = '0;
    last = px_q.size() - 1;
    for (int r = 0; r < K; r++)
      for (int j = 0; j < K; j++)
        w[((K-1-r)*K + (K-1-j))*N +: N] = N'(px_q[last - r*LINES - j]);
    return w;
  endfunction

  function automatic bit window_known();
    return (px_q.size() - 1 - (K-1)*LINES - (K-1)) >= 0;
  endfunction

  function automatic logic [K*K*M-1:0] model_wgrp();
    logic [K*K*M-1:0] w;
    int c;
    w = '0;
    c = w_q.size();
    for (int i = 0; i < KK; i++)
      if (c - 1 - i >= 0) w[(KK-1-i)*M +: M] = M'(w_q[c-1-i]);
    return w;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      px_q.delete();
      w_q.delete();
      exp_q.delete();
      pos = 0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (en_in) begin
        if (sof) pos = 0;
        p_row = (pos / LINES > K-1) ? K-1 : pos / LINES;
        p_col = pos % LINES;
        pos++;
        px_q.push_back(int'(d_in));
        m_valid = (p_row == K-1) && (p_col >= K-1);
        if (m_valid) exp_q.push_back(model_window());
      end
      if (w_conf) w_q.push_back(int'(w_in));
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (check_on) begin
      check("win_valid", win_valid, m_valid);
      if (win_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL win_unexpected: got window %0h expected none", d_grp);
        end else begin
          check("win_data", d_grp, exp_q.pop_front());
        end
      end
      if (px_q.size() == 0)  check("d_grp_clear", d_grp, '0);
      else if (window_known()) check("d_grp_hold", d_grp, model_window());
      check("w_grp", w_grp, model_wgrp());
      check("w_out", w_out, (w_q.size() > KK) ? w_q[w_q.size()-1-KK] : 0);
      check("w_ready", w_ready, (w_q.size() > 0) && (w_q.size() % KK == 0));
    end
  end

  int                 acc5 = 0;
  int                 first5 = -1;
  logic [K5*K5*8-1:0] first_win5 = '0;
  int                 px5[0:511];

  always @(negedge clk) begin
    if (check5_on) begin
      check("k5_valid_match", v5a, v5b);
      if (v5a) begin
        check("k5_window_match", d_grp5a, d_grp5b);
        if (first5 < 0) begin
          first5 = acc5 - 1;
          first_win5 = d_grp5a;
        end
      end
    end
  end

  // --------------------------------------------------------- driver tasks
  task automatic cyc(input logic e, input logic s, input int d, input logic wc, input int wi);
    @(negedge clk);
    #1;
    rst_n = 1'b1; en_in = e; sof = s; d_in = N'(d); w_conf = wc; w_in = M'(wi);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic e, input logic wc);
    @(negedge clk);
    #1;
    rst_n = 1'b0; en_in = e; sof = e; d_in = N'($urandom_range(0, 255));
    w_conf = wc; w_in = M'($urandom_range(0, 15));
    @(posedge clk);
    #2;
    check("rst_win_valid", win_valid, 0);
    check("rst_d_grp", d_grp, 0);
    check("rst_w_grp", w_grp, 0);
    check("rst_w_out", w_out, 0);
    check("rst_w_ready", w_ready, 0);
  endtask

  task automatic cyc5(input logic e, input logic s, input int d);
    @(negedge clk);
    #1;
    en_in = 1'b0; sof = 1'b0; w_conf = 1'b0;
    en5 = e; sof5 = s; d5 = 8'(d);
    if (e) begin
      px5[acc5] = d;
      acc5++;
    end
    @(posedge clk);
    #2;
  endtask

  // ------------------------------------------------------------ sequence
  logic [K*K*N-1:0] w18;
  logic [K*K*N-1:0] wsof;
  logic [K*K*M-1:0] wg9;

  initial begin
    w18  = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    wsof = {8'd39, 8'd38, 8'd37, 8'd31, 8'd30, 8'd29, 8'd23, 8'd22, 8'd21};
    wg9  = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    // Continuous raster, 4 lines.
    do_reset(1'b0, 1'b0);
    check_on = 1'b1;
    pulse_cnt = 0;
    for (int n = 0; n < 4*LINES; n++) begin
      cyc(1'b1, n == 0, n, 1'b0, 0);
      if (n == 17) check("no_valid_before_18", win_valid, 0);
      if (n == 18) begin
        check("first_valid", win_valid, 1);
        check("first_window", d_grp, w18);
      end
    end
    cyc(1'b0, 1'b0, 0, 1'b0, 0);
    check("pulses_continuous", pulse_cnt, 12);

    // Same stream, en_in every other cycle; en/w_conf held high in reset.
    do_reset(1'b1, 1'b1);
    pulse_cnt = 0;
    for (int n = 0; n < 4*LINES; n++) begin
      cyc(1'b1, n == 0, n, 1'b0, 0);
      if (n == 18) begin
        check("gap_first_valid", win_valid, 1);
        check("gap_first_window", d_grp, w18);
      end
      cyc(1'b0, 1'b0, $urandom_range(0, 255), 1'b0, 0);
      if (n == 18) begin
        check("gap_idle_valid", win_valid, 0);
        check("gap_idle_hold", d_grp, w18);
      end
    end
    check("pulses_gapped", pulse_cnt, 12);

    // Weight load, partly coinciding with pixel accepts.
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= KK; i++) begin
      cyc(logic'(i % 2), i == 1, 100 + i, 1'b1, i);
      if (i == KK-1) check("w_ready_before_9", w_ready, 0);
    end
    check("w_grp_loaded", w_grp, wg9);
    check("w_ready_after_9", w_ready, 1);
    cyc(1'b1, 1'b0, 110, 1'b1, 10);
    check("w_out_10th", w_out, 1);
    check("w_ready_10th", w_ready, 0);

    // sof at (2,5) of a running frame.
    do_reset(1'b0, 1'b0);
    pulse_cnt = 0;
    for (int n = 0; n < 46; n++) begin
      cyc(1'b1, (n == 0) || (n == 21), n, 1'b0, 0);
      if (n == 21) check("pulses_before_sof", pulse_cnt, 3);
      if (n == 38) check("no_valid_after_sof", pulse_cnt, 3);
      if (n == 39) begin
        check("sof_first_valid", win_valid, 1);
        check("sof_first_window", d_grp, wsof);
      end
    end

    // One-cycle reset in the middle of a frame, then refill.
    for (int n = 0; n < 13; n++) cyc(1'b1, n == 0, n + 50, n == 5, n);
    do_reset(1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      cyc(1'b1, n == 0, n, 1'b0, 0);
      if (n == 17) check("refill_no_valid", win_valid, 0);
      if (n == 18) begin
        check("refill_valid", win_valid, 1);
        check("refill_window", d_grp, w18);
      end
    end
    cyc(1'b0, 1'b0, 0, 1'b0, 0);

    // K=5, LINES=16: shift-chain vs RAM on random data with random gaps.
    check5_on = 1'b1;
    for (int i = 0; i < 400 && acc5 < 6*L5; i++) begin
      logic e;
      e = ($urandom_range(0, 3) != 0);
      cyc5(e, e && (acc5 == 0), $urandom_range(0, 255));
    end
    cyc5(1'b0, 1'b0, 0);
    check("k5_first_index", first5, 4*L5 + 4);
    check("k5_first_newest", first_win5[K5*K5*8-1 -: 8], (first5 >= 0) ? px5[first5] : -1);
    check("k5_first_oldest", first_win5[7:0], (first5 >= 0) ? px5[first5 - 4*L5 - 4] : -1);

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Parametrised successor to the fixed 3x3 window/weight staging block in the PE datapath.
- Takes a raster pixel stream and produces a KxK sliding window (d_grp) plus a KxK weight group (w_grp) for the MAC array.
- Real line delays (RAM or register) are sized from LINES and K, so row alignment is exact.
- Adds position tracking, a window-valid strobe, frame restart and weight-load completion.

Parameters:
- LINES, 16, pixels per image line; must satisfy LINES > K.
- K, 3, kernel size (3..7).
- N, 8, pixel data width.
- M, 4, weight width.
- USE_MEM, 1, 1 = line delays are circular RAM arrays with pointer; 0 = register shift chains. Behaviour is identical.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- sof  in  1  start of frame; qualified by en_in; marks the current pixel as (row 0, col 0).
- d_in  in  N  pixel data.
- en_in  in  1  pixel accept strobe.
- w_in  in  M  weight data.
- w_conf  in  1  weight shift enable.
- w_out  out  M  weight cascade output to the next PE.
- w_ready  out  1  K*K weights loaded since last restart.
- d_grp  out  K*K*N  window; row 0 (newest line) in the MSBs; within a row, newest column in the MSBs.
- w_grp  out  K*K*M  weights; first-stage register in the MSBs.
- win_valid  out  1  d_grp holds a complete window.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Window taps, weight regs, w_out, counters, w_ready and win_valid all go to 0.
  - Line-delay storage is not cleared; stale contents are masked by win_valid.
- Window structure: K rows of K-stage tap registers.
  - Row 0 tap 0 is loaded from d_in.
  - Row r tap 0 is loaded from the output of line delay r-1.
  - Line delay r-1 is fed by row r-1 tap K-1 and has depth D = LINES-K.
  - Total row-to-row delay is therefore exactly LINES accepted pixels.
  - K-1 line delays in total.
- Advance: all taps, line delays and counters advance only on edges with en_in=1. With en_in=0 every register holds.
- RAM mode: a single shared pointer counts 0..D-1 and wraps to 0. Each access is read-before-write at the same address in the same cycle.
- Position counters:
  - col counts 0..LINES-1 and wraps to 0; on wrap, row increments.
  - row saturates at K-1.
  - Counters give the position of the pixel being accepted.
  - sof&en_in forces that pixel to (0,0); next position is (0,1).
  - sof without en_in is ignored.
- win_valid:
  - Registered. On an accepting edge for pixel (r,c): win_valid <= (r==K-1 && c>=K-1). On all other edges: win_valid <= 0.
  - High exactly one cycle, aligned with the d_grp containing that window. Latency from d_in to window is 1 clk.
  - No valid windows straddle line wrap (c<K-1 suppressed).
- Weights: K*K-stage shift chain, enabled by w_conf.
  - w_out <= last stage on each w_conf edge.
  - A load counter counts w_conf edges, saturating at K*K.
  - w_ready = (count == K*K).
  - The first w_conf after w_ready=1 restarts the count at 1 and drops w_ready.
- Independence: w_conf and en_in are independent and may coincide.
- Mid-operation reset or sof: the next valid window requires K-1 further full lines plus K pixels.

Decomposition:
- Shared package cnn_pe_pkg:
  - clog2 function.
  - Window ordering constants (row-major, newest-first).
  - K_MIN/K_MAX legality check used by an elaboration-time assertion (LINES > K, K in range).
- One sub-module, line_delay:
  - Parameters W, DEPTH, USE_MEM; ports clk, en, din, dout.
  - Instantiated K-1 times in a generate loop.

Test Plan:
- LINES=8, K=3, N=8: raster pixels valued r*8+c with continuous en_in.
  - First win_valid follows pixel 18.
  - d_grp = {18,17,16, 10,9,8, 2,1,0}.
  - Over 4 lines, exactly 12 win_valid pulses at c=2..7 of lines 2 and 3.
- Same stream with en_in toggled every other cycle: identical d_grp sequence; win_valid only one cycle after accepting edges; all state held on idle cycles.
- Nine w_conf with w_in=1..9 (M=4):
  - w_grp = {9,8,7,6,5,4,3,2,1}; w_ready rises after the 9th.
  - 10th w_conf with 10 gives w_out=1 and w_ready=0.
- sof at pixel (2,5) mid-frame: no win_valid until relative pixel (2,2); first window contains only post-sof pixels.
- rst_n low for 1 clk mid-frame: all outputs 0 next cycle; refill behaves as at power-up; en_in and w_conf asserted during reset are ignored.
- K=5, LINES=16: run USE_MEM=0 and USE_MEM=1 side by side on random data; d_grp and win_valid identical every cycle; first window after pixel 4*16+4.
